rv32_lsu: RTL and testbench

Load/store unit between execute and the register-file write port. Takes one memory operation at a time from execute over a valid/ready handshake and drives a word-aligned request/grant/response data bus. Stores get byte-lane alignment, and load data gets lane extraction plus sign/zero extension. Each completed load produces a single-cycle write-back pulse (`wb_we_o`/`wb_waddr_o`/`wb_wdata_o`) that connects directly to the register file's write port.

---
 rtl/rv32_lsu.sv | 149 ++++++++++++++
 tb/tb_rv32_lsu.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/rv32_lsu.sv
// Load/store unit: one operation at a time from execute to a word-aligned req/gnt/rvalid bus.
// Handles byte-lane alignment for stores, lane extraction and sign/zero extension for loads.
module rv32_lsu #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic              is_store_i,
  input  logic [2:0]        funct3_i,
  input  logic [XLEN-1:0]   addr_i,
  input  logic [XLEN-1:0]   sdata_i,
  input  logic [ADDR_W-1:0] rd_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [XLEN-1:0]   mem_addr_o,
  output logic [3:0]        mem_be_o,
  output logic [XLEN-1:0]   mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [XLEN-1:0]   mem_rdata_i,
  output logic              wb_we_o,
  output logic [ADDR_W-1:0] wb_waddr_o,
  output logic [XLEN-1:0]   wb_wdata_o,
  output logic              err_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t state_q, state_d;

  logic              legal, aligned, accept, go;
  logic [3:0]        be_d;
  logic [XLEN-1:0]   wdata_d;
  logic              req_q, we_q, err_q, wb_we_q;
  logic [2:0]        f3_q;
  logic [1:0]        off_q;
  logic [ADDR_W-1:0] rd_q;
  logic [XLEN-1:0]   addr_q, wdata_q;
  logic [3:0]        be_q;
  logic [XLEN-1:0]   lane, load_val;

  assign accept = valid_i && (state_q == IDLE);
  assign go     = accept && legal && aligned;

  always_comb begin
    legal   = is_store_i ? (funct3_i < 3'd3)
                         : (funct3_i inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    aligned = 1'b1;
    case (funct3_i[1:0])
      2'd1:    aligned = ~addr_i[0];
      2'd2:    aligned = (addr_i[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase
  end

  // Lane selection also applies to loads so the bus sees which bytes are wanted.
  always_comb begin
    be_d    = 4'b1111;
    wdata_d = sdata_i;
    case (funct3_i[1:0])
      2'd0: begin
        be_d    = 4'b0001 << addr_i[1:0];
        wdata_d = {4{sdata_i[7:0]}};
      end
      2'd1: begin
        be_d    = addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{sdata_i[15:0]}};
      end
      default: begin
        be_d    = 4'b1111;
        wdata_d = sdata_i;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (go) state_d = REQ;
      REQ:     if (mem_gnt_i) state_d = we_q ? IDLE : WAIT;
      WAIT:    if (mem_rvalid_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    lane     = mem_rdata_i >> {off_q, 3'b000};
    load_val = lane;
    case (f3_q)
      3'd0:    load_val = {{(XLEN-8){lane[7]}}, lane[7:0]};
      3'd1:    load_val = {{(XLEN-16){lane[15]}}, lane[15:0]};
      3'd4:    load_val = {{(XLEN-8){1'b0}}, lane[7:0]};
      3'd5:    load_val = {{(XLEN-16){1'b0}}, lane[15:0]};
      default: load_val = lane;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      wb_we_q    <= 1'b0;
      f3_q       <= 3'd0;
      off_q      <= 2'd0;
      rd_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= 4'd0;
      wb_waddr_o <= '0;
      wb_wdata_o <= '0;
    end else begin
      req_q   <= (state_d == REQ);
      err_q   <= accept && !(legal && aligned);
      wb_we_q <= (state_q == WAIT) && mem_rvalid_i && (rd_q != '0);
      if (go) begin
        we_q    <= is_store_i;
        f3_q    <= funct3_i;
        off_q   <= addr_i[1:0];
        rd_q    <= rd_i;
        addr_q  <= {addr_i[XLEN-1:2], 2'b00};
        wdata_q <= wdata_d;
        be_q    <= be_d;
      end
      if ((state_q == WAIT) && mem_rvalid_i) begin
        wb_waddr_o <= rd_q;
        wb_wdata_o <= load_val;
      end
    end
  end

  assign ready_o     = (state_q == IDLE);
  assign mem_req_o   = req_q;
  assign mem_we_o    = req_q & we_q;
  assign mem_be_o    = req_q ? be_q : 4'b0000;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign wb_we_o     = wb_we_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_rv32_lsu.sv
// Directed bench for rv32_lsu: inputs driven and outputs sampled on the falling edge.
module tb_rv32_lsu;
  logic        clk_i = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_i = 1'b0, is_store_i = 1'b0;
  logic [2:0]  funct3_i = 3'd0;
  logic [31:0] addr_i = '0, sdata_i = '0, mem_rdata_i = '0;
  logic [4:0]  rd_i = '0;
  logic        mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0;
  logic        ready_o, mem_req_o, mem_we_o, wb_we_o, err_o;
  logic [31:0] mem_addr_o, mem_wdata_o, wb_wdata_o;
  logic [3:0]  mem_be_o;
  logic [4:0]  wb_waddr_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  rv32_lsu #(.XLEN(32), .ADDR_W(5)) dut (
    .clk_i(clk_i), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_o),
    .is_store_i(is_store_i), .funct3_i(funct3_i), .addr_i(addr_i), .sdata_i(sdata_i),
    .rd_i(rd_i), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .wb_we_o(wb_we_o),
    .wb_waddr_o(wb_waddr_o), .wb_wdata_o(wb_wdata_o), .err_o(err_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_ready"}, ready_o, 1);
    chk({tag, "_req"}, mem_req_o, 0);
    chk({tag, "_be"}, mem_be_o, 0);
    chk({tag, "_wbwe"}, wb_we_o, 0);
    chk({tag, "_err"}, err_o, 0);
  endtask

  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] sd, input logic [4:0] rd);
    @(negedge clk_i);
    valid_i = 1'b1; is_store_i = st; funct3_i = f3; addr_i = a; sdata_i = sd; rd_i = rd;
    @(negedge clk_i);
    valid_i = 1'b0;
  endtask

  // Zero-wait load: grant in first REQ cycle, rvalid in first WAIT cycle.
  task automatic load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                      input logic [4:0] rd, input logic [31:0] rdata, input logic [3:0] be,
                      input logic [31:0] exp_data, input logic exp_we);
    issue(1'b0, f3, a, 32'h0, rd);
    chk({tag, "_req"}, mem_req_o, 1);
    chk({tag, "_ready"}, ready_o, 0);
    chk({tag, "_addr"}, mem_addr_o, {a[31:2], 2'b00});
    chk({tag, "_be"}, mem_be_o, be);
    chk({tag, "_we"}, mem_we_o, 0);
    mem_gnt_i = 1'b1;
    @(negedge clk_i);
    mem_gnt_i = 1'b0;
    chk({tag, "_reqdrop"}, mem_req_o, 0);
    chk({tag, "_wbearly"}, wb_we_o, 0);
    mem_rvalid_i = 1'b1; mem_rdata_i = rdata;
    @(negedge clk_i);
    mem_rvalid_i = 1'b0;
    chk({tag, "_wbwe"}, wb_we_o, exp_we);
    chk({tag, "_rdyback"}, ready_o, 1);
    if (exp_we) begin
      chk({tag, "_waddr"}, wb_waddr_o, rd);
      chk({tag, "_wdata"}, wb_wdata_o, exp_data);
    end
    @(negedge clk_i);
    chk({tag, "_wbpulse"}, wb_we_o, 0);
  endtask

  task automatic bad_op(input string tag, input logic st, input logic [2:0] f3,
                        input logic [31:0] a);
    issue(st, f3, a, 32'h1234_5678, 5'd9);
    chk({tag, "_err"}, err_o, 1);
    chk({tag, "_req"}, mem_req_o, 0);
    chk({tag, "_ready"}, ready_o, 1);
    @(negedge clk_i);
    check_idle_outputs({tag, "_after"});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk_i);
    check_idle_outputs("reset");
    chk("reset_addr", mem_addr_o, 0);
    chk("reset_wdata", wb_wdata_o, 0);
    rst_n = 1'b1;
    @(negedge clk_i);

    load("lw", 3'd2, 32'h100, 5'd5, 32'hDEADBEEF, 4'hF, 32'hDEADBEEF, 1'b1);
    load("lb", 3'd0, 32'h103, 5'd6, 32'h80FF1234, 4'h8, 32'hFFFFFF80, 1'b1);
    load("lbu", 3'd4, 32'h103, 5'd6, 32'h80FF1234, 4'h8, 32'h00000080, 1'b1);
    load("lh", 3'd1, 32'h102, 5'd7, 32'h80FF1234, 4'hC, 32'hFFFF80FF, 1'b1);
    load("lhu", 3'd5, 32'h102, 5'd7, 32'h80FF1234, 4'hC, 32'h000080FF, 1'b1);
    load("lb1", 3'd0, 32'h101, 5'd8, 32'h80FF1234, 4'h2, 32'h00000012, 1'b1);
    load("lx0", 3'd2, 32'h010, 5'd0, 32'h12345678, 4'hF, 32'h0, 1'b0);

    // SB with three grant-wait cycles: request and payload must stay stable.
    issue(1'b1, 3'd0, 32'h202, 32'h0000_00A5, 5'd0);
    for (int i = 0; i < 4; i++) begin
      chk("sb_req", mem_req_o, 1);
      chk("sb_we", mem_we_o, 1);
      chk("sb_addr", mem_addr_o, 32'h200);
      chk("sb_be", mem_be_o, 4'h4);
      chk("sb_wdata", mem_wdata_o, 32'hA5A5A5A5);
      chk("sb_ready", ready_o, 0);
      chk("sb_wbwe", wb_we_o, 0);
      if (i == 3) mem_gnt_i = 1'b1;
      @(negedge clk_i);
    end
    mem_gnt_i = 1'b0;
    check_idle_outputs("sb_done");
    chk("sb_we_drop", mem_we_o, 0);

    issue(1'b1, 3'd1, 32'h306, 32'hCAFE_1357, 5'd0);
    chk("sh_be", mem_be_o, 4'hC);
    chk("sh_wdata", mem_wdata_o, 32'h13571357);
    mem_gnt_i = 1'b1;
    @(negedge clk_i);
    mem_gnt_i = 1'b0;
    check_idle_outputs("sh_done");

    bad_op("lw_mis", 1'b0, 3'd2, 32'h101);
    bad_op("sh_mis", 1'b1, 3'd1, 32'h003);
    bad_op("ld_f3", 1'b0, 3'd3, 32'h100);
    bad_op("st_f3", 1'b1, 3'd4, 32'h100);

    // Reset asserted while waiting for read data; the late rvalid must be dropped.
    issue(1'b0, 3'd2, 32'h400, 32'h0, 5'd11);
    mem_gnt_i = 1'b1;
    @(negedge clk_i);
    mem_gnt_i = 1'b0;
    chk("rst_inwait", ready_o, 0);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("rst_async");
    chk("rst_addr", mem_addr_o, 0);
    chk("rst_wdata", mem_wdata_o, 0);
    chk("rst_waddr", wb_waddr_o, 0);
    chk("rst_wbdata", wb_wdata_o, 0);
    @(negedge clk_i);
    rst_n = 1'b1;
    @(negedge clk_i);
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h5555AAAA;
    @(negedge clk_i);
    mem_rvalid_i = 1'b0;
    check_idle_outputs("rst_late_rvalid");
    chk("rst_late_wdata", wb_wdata_o, 0);

    load("post_rst", 3'd2, 32'h500, 5'd12, 32'h0BADF00D, 4'hF, 32'h0BADF00D, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
